// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 control unit: FSM states, opcode groups,
// branch condition codes and PSR flag bit positions.
package cr16_pkg;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DECODE  = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   // Opcode groups selected by IR[15:12]
   localparam logic [3:0] OPC_REG   = 4'h0;
   localparam logic [3:0] OPC_BCOND = 4'hC;

   localparam logic [7:0] ALU_ADD = 8'h05;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_GT = 4'b0110;
   localparam logic [3:0] COND_LE = 4'b0111;
   localparam logic [3:0] COND_UC = 4'b1110;

   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   function automatic logic [15:0] sext8(input logic [7:0] value);
      return {{8{value[7]}}, value};
   endfunction

endpackage

// File: rtl/cr16_branch_cond.sv
// Combinational branch condition evaluator: decides whether a Bcond
// instruction is taken from the latched PSR and the 4-bit condition code.
module cr16_branch_cond
   import cr16_pkg::*;
(
   input  logic [4:0] psr,
   input  logic [3:0] cond,
   output logic       taken
);

   // L and F flags are latched in the PSR but no condition inspects them
   logic unused_lf;
   assign unused_lf = psr[FLAG_L] ^ psr[FLAG_F];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = psr[FLAG_Z];
         COND_NE: taken = ~psr[FLAG_Z];
         COND_CS: taken = psr[FLAG_C];
         COND_CC: taken = ~psr[FLAG_C];
         COND_GT: taken = psr[FLAG_N];
         COND_LE: taken = ~psr[FLAG_N];
         COND_UC: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cr16_control_fsm.sv
// CR16 control FSM: FETCH/DECODE/EXECUTE/HALT sequencing with IR, pc and PSR.
// Define CR16_COND_BRANCH_EN to enable conditional branches (else 1100 is a NOP).
module cr16_control_fsm
   import cr16_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   output logic        instr_req,
   output logic [15:0] instr_addr,
   input  logic        instr_ack,
   input  logic [15:0] instr_data,
   input  logic [4:0]  alu_flags,
   input  logic [15:0] alu_result,
   output logic [3:0]  ra,
   output logic [3:0]  rb,
   output logic [15:0] immediate,
   output logic [7:0]  OP,
   output logic        im_mux,
   output logic        pc_mux,
   output logic        regwrt,
   output logic [15:0] pc,
   output logic        halted
);

   state_t      state;
   logic [15:0] ir;
   logic [4:0]  psr;
   logic [3:0]  opc;
   logic        is_reg;
   logic        is_bcond;
   logic        in_decode_exec;
   logic        taken;

   assign opc            = ir[15:12];
   assign is_reg         = (opc == OPC_REG);
   assign is_bcond       = (opc == OPC_BCOND);
   assign in_decode_exec = (state == ST_DECODE) || (state == ST_EXECUTE);
   assign instr_addr     = pc;

`ifdef CR16_COND_BRANCH_EN
   cr16_branch_cond u_branch_cond (
      .psr   (psr),
      .cond  (ir[11:8]),
      .taken (taken)
   );
`else
   // Without branch support the PSR is still maintained but never consulted
   logic unused_psr;
   assign unused_psr = ^psr;
   assign taken      = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_FETCH;
         pc    <= RESET_PC;
         ir    <= 16'h0000;
         psr   <= 5'b00000;
      end else begin
         case (state)
            ST_FETCH: begin
               if (instr_ack) begin
                  ir    <= instr_data;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               state <= (ir == HALT_WORD) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
               state <= ST_FETCH;
               if (is_bcond) begin
                  pc <= taken ? alu_result : pc + 16'd1;
               end else begin
                  psr <= alu_flags;
                  pc  <= pc + 16'd1;
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

   // Outputs are gated by reset so they drop the instant reset rises
   always_comb begin
      instr_req = 1'b0;
      ra        = 4'h0;
      rb        = 4'h0;
      immediate = 16'h0000;
      OP        = 8'h00;
      im_mux    = 1'b0;
      pc_mux    = 1'b0;
      regwrt    = 1'b0;
      halted    = 1'b0;
      if (!reset) begin
         instr_req = (state == ST_FETCH);
         halted    = (state == ST_HALT);
         regwrt    = (state == ST_EXECUTE) && !is_bcond;
         if (in_decode_exec) begin
            ra = ir[11:8];
            rb = ir[3:0];
            if (is_reg) begin
               OP = {4'h0, ir[7:4]};
            end else if (is_bcond) begin
`ifdef CR16_COND_BRANCH_EN
               OP        = ALU_ADD;
               im_mux    = 1'b1;
               pc_mux    = 1'b1;
               immediate = sext8(ir[7:0]);
`endif
            end else begin
               OP        = {opc, 4'h0};
               im_mux    = 1'b1;
               immediate = sext8(ir[7:0]);
            end
         end
      end
   end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Scoreboard bench for cr16_control_fsm: a driver feeds instructions and pushes
// expected responses from a reference model; a monitor pops and compares.
module tb_cr16_control_fsm;

   logic        clk;
   logic        reset;
   logic        instr_req;
   logic [15:0] instr_addr;
   logic        instr_ack;
   logic [15:0] instr_data;
   logic [4:0]  alu_flags;
   logic [15:0] alu_result;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [15:0] immediate;
   logic [7:0]  OP;
   logic        im_mux;
   logic        pc_mux;
   logic        regwrt;
   logic [15:0] pc;
   logic        halted;

   cr16_control_fsm dut (
      .clk        (clk),
      .reset      (reset),
      .instr_req  (instr_req),
      .instr_addr (instr_addr),
      .instr_ack  (instr_ack),
      .instr_data (instr_data),
      .alu_flags  (alu_flags),
      .alu_result (alu_result),
      .ra         (ra),
      .rb         (rb),
      .immediate  (immediate),
      .OP         (OP),
      .im_mux     (im_mux),
      .pc_mux     (pc_mux),
      .regwrt     (regwrt),
      .pc         (pc),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] fetch_pc;
      logic        halt;
      logic [7:0]  op;
      logic        im;
      logic        pm;
      logic        wr;
      logic [15:0] imm;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [15:0] next_pc;
   } exp_t;

   exp_t        sb_q[$];
   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [15:0] model_pc;
   logic [4:0]  model_psr;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic cond_holds(input logic [3:0] cond, input logic [4:0] flags);
      logic c;
      logic z;
      logic n;
      c = flags[0];
      z = flags[3];
      n = flags[4];
      case (cond)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return c;
         4'd3:    return !c;
         4'd6:    return n;
         4'd7:    return !n;
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Model one instruction, push its expectation, then hand it to the DUT
   task automatic applyStimulus(input logic [15:0] instr, input int waits,
                                input logic [4:0] flags, input logic [15:0] result);
      exp_t        e;
      int          guard;
      logic [15:0] disp;
      disp       = 16'($signed(instr[7:0]));
      e.fetch_pc = model_pc;
      e.halt     = 1'b0;
      e.op       = 8'h00;
      e.im       = 1'b0;
      e.pm       = 1'b0;
      e.wr       = 1'b0;
      e.imm      = 16'h0000;
      e.ra       = instr[11:8];
      e.rb       = instr[3:0];
      e.next_pc  = model_pc + 16'd1;
      if (instr == 16'hFFFF) begin
         e.halt    = 1'b1;
         e.next_pc = model_pc;
      end else if (instr[15:12] == 4'h0) begin
         e.op      = {4'h0, instr[7:4]};
         e.wr      = 1'b1;
         model_psr = flags;
      end else if (instr[15:12] == 4'hC) begin
`ifdef CR16_COND_BRANCH_EN
         e.op  = 8'h05;
         e.im  = 1'b1;
         e.pm  = 1'b1;
         e.imm = disp;
         if (cond_holds(instr[11:8], model_psr)) e.next_pc = result;
`endif
      end else begin
         e.op      = {instr[15:12], 4'h0};
         e.im      = 1'b1;
         e.wr      = 1'b1;
         e.imm     = disp;
         model_psr = flags;
      end
      model_pc = e.next_pc;
      sb_q.push_back(e);

      guard = 0;
      while (instr_req !== 1'b1) begin
         instr_ack  = 1'($urandom);
         instr_data = 16'($urandom);
         @(posedge clk);
         #1;
         guard++;
         if (guard > 10) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL fetch_timeout: instr_req=%b expected 1 within 10 cycles", instr_req);
            return;
         end
      end
      instr_ack = 1'b0;
      repeat (waits) begin
         instr_data = 16'($urandom);
         @(posedge clk);
         #1;
      end
      instr_ack  = 1'b1;
      instr_data = instr;
      alu_flags  = flags;
      alu_result = result;
      @(posedge clk);
      #1;
      instr_ack  = 1'b0;
      instr_data = 16'($urandom);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb_q.size() != 0 && g < 20) begin
         @(posedge clk);
         #1;
         g++;
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("scoreboard_drain", 16'(sb_q.size()), 16'd0);
   endtask

   function automatic logic [15:0] rand_instr();
      logic [3:0] op;
      case ($urandom_range(0, 3))
         0:       return {4'h0, 12'($urandom)};
         1: begin
            op = 4'($urandom_range(1, 11));
            return {op, 12'($urandom)};
         end
         default: return {4'hC, 12'($urandom)};
      endcase
   endfunction

   // Monitor: tracks fetch acceptance, then checks DECODE and EXECUTE cycles
   initial begin
      int   phase;
      logic pend;
      logic [15:0] exp_pc;
      exp_t cur;
      phase = 0;
      pend  = 1'b0;
      exp_pc = 16'h0000;
      forever begin
         @(negedge clk);
         if (reset) begin
            phase = 0;
            pend  = 1'b0;
         end else begin
            case (phase)
               0: begin
                  if (pend) begin
                     checkOutput("pc_after_execute", pc, exp_pc);
                     pend = 1'b0;
                  end
                  if (instr_req && sb_q.size() > 0) begin
                     checkOutput("instr_addr", instr_addr, sb_q[0].fetch_pc);
                     if (instr_ack) phase = 1;
                  end
               end
               1: begin
                  checkOutput("decode_instr_req", 16'(instr_req), 16'd0);
                  checkOutput("decode_regwrt", 16'(regwrt), 16'd0);
                  phase = 2;
               end
               2: begin
                  cur = sb_q.pop_front();
                  if (cur.halt) begin
                     checkOutput("halt_halted", 16'(halted), 16'd1);
                     checkOutput("halt_instr_req", 16'(instr_req), 16'd0);
                     checkOutput("halt_regwrt", 16'(regwrt), 16'd0);
                     phase = 3;
                  end else begin
                     checkOutput("exec_regwrt", 16'(regwrt), 16'(cur.wr));
                     checkOutput("exec_OP", 16'(OP), 16'(cur.op));
                     checkOutput("exec_im_mux", 16'(im_mux), 16'(cur.im));
                     checkOutput("exec_pc_mux", 16'(pc_mux), 16'(cur.pm));
                     checkOutput("exec_immediate", immediate, cur.imm);
                     checkOutput("exec_ra", 16'(ra), 16'(cur.ra));
                     checkOutput("exec_rb", 16'(rb), 16'(cur.rb));
                     pend   = 1'b1;
                     exp_pc = cur.next_pc;
                     phase  = 0;
                  end
               end
               default: begin
                  checkOutput("halt_hold_halted", 16'(halted), 16'd1);
                  checkOutput("halt_hold_instr_req", 16'(instr_req), 16'd0);
                  checkOutput("halt_hold_pc", pc, cur.next_pc);
               end
            endcase
         end
      end
   end

   initial begin
      reset      = 1'b1;
      instr_ack  = 1'b0;
      instr_data = 16'h0000;
      alu_flags  = 5'b00000;
      alu_result = 16'h0000;
      model_pc   = 16'h0000;
      model_psr  = 5'b00000;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_instr_req", 16'(instr_req), 16'd0);
      checkOutput("reset_regwrt", 16'(regwrt), 16'd0);
      checkOutput("reset_halted", 16'(halted), 16'd0);
      checkOutput("reset_pc", pc, 16'h0000);
      checkOutput("reset_OP", 16'(OP), 16'd0);
      checkOutput("reset_muxes", 16'({im_mux, pc_mux}), 16'd0);
      checkOutput("reset_immediate", immediate, 16'h0000);
      reset = 1'b0;
      #1;
      checkOutput("release_instr_req", 16'(instr_req), 16'd1);
      checkOutput("release_instr_addr", instr_addr, 16'h0000);

      applyStimulus(16'h0251, 0, 5'b00000, 16'h0000);
      applyStimulus(16'h5AFE, 0, 5'b01000, 16'h1234);
      applyStimulus(16'hC0FC, 0, 5'b00000, 16'h0006);
      applyStimulus(16'h0123, 0, 5'b00000, 16'h0000);
      applyStimulus(16'hC0FC, 0, 5'b01000, 16'h0006);
      applyStimulus(16'h3101, 4, 5'($urandom), 16'($urandom));
`ifdef CR16_COND_BRANCH_EN
      applyStimulus(16'hCE00, 1, 5'($urandom), 16'hFFFF);
      applyStimulus(16'h1000, 0, 5'($urandom), 16'($urandom));
`endif
      for (int i = 0; i < 120; i++) begin
         applyStimulus(rand_instr(), $urandom_range(0, 3), 5'($urandom), 16'($urandom));
      end
      drain();

      applyStimulus(16'h0452, 0, 5'b11111, 16'h0000);
      @(posedge clk);
      #1;
      checkOutput("pre_reset_regwrt", 16'(regwrt), 16'd1);
      reset = 1'b1;
      #1;
      checkOutput("async_reset_regwrt", 16'(regwrt), 16'd0);
      checkOutput("async_reset_instr_req", 16'(instr_req), 16'd0);
      checkOutput("async_reset_pc", pc, 16'h0000);
      sb_q.delete();
      model_pc  = 16'h0000;
      model_psr = 5'b00000;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rerelease_instr_req", 16'(instr_req), 16'd1);
      checkOutput("rerelease_instr_addr", instr_addr, 16'h0000);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(rand_instr(), $urandom_range(0, 2), 5'($urandom), 16'($urandom));
      end
      applyStimulus(16'hFFFF, 1, 5'($urandom), 16'($urandom));
      repeat (6) @(posedge clk);
      #1;
      checkOutput("halt_scoreboard_empty", 16'(sb_q.size()), 16'd0);
      reset = 1'b1;
      #1;
      checkOutput("halt_reset_halted", 16'(halted), 16'd0);
      checkOutput("halt_reset_pc", pc, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("halt_exit_instr_req", 16'(instr_req), 16'd1);
      checkOutput("halt_exit_instr_addr", instr_addr, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
